// File: rtl/btn_sel_ctrl_pkg.sv
// Shared definitions for the button-driven tap selector: step FSM state
// encodings, default timing constants for a 12 MHz CLK, and a counter width helper.
package btn_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    BOTH   = 2'd3
  } step_state_t;

  localparam int unsigned DEF_DEB_CYCLES   = 240000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY = 6000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE  = 1200000;  // 0.1 s

  // Bits needed to hold values 0 .. n-1 (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchroniser followed by a stability counter. The debounced level
// follows the synchronised level only after it has differed from the current
// debounced level for DEB_CYCLES consecutive cycles.
module btn_debounce
  import btn_sel_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_RAW,
  output logic BTN_DB
);

  localparam int unsigned CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the CLK domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN_RAW;
      sync2 <= sync1;
    end
  end

  // Restart the count on any agreement; commit the new level once it has held long enough.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= '0;
      BTN_DB <= 1'b0;
    end else if (sync2 == BTN_DB) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      BTN_DB <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_sel_ctrl.sv
// Selector index controller: debounces the up/down buttons, turns presses into
// single-cycle steps with auto-repeat, and keeps SEL synchronous to CLK.
// Optional macro SEL_WRAP_EN: SEL wraps at the bounds and AT_LIMIT is tied low;
// without it SEL saturates at 0 and SEL_MAX.
module btn_sel_ctrl
  import btn_sel_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W        = 5,
  parameter int unsigned SEL_MAX      = 31,
  parameter int unsigned SEL_INIT     = 0,
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN_UP,
  input  logic             BTN_DN,
  output logic [SEL_W-1:0] SEL,
  output logic             UP_PULSE,
  output logic             DN_PULSE,
  output logic             AT_LIMIT
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DELAY_LD = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] RATE_LD  = TMR_W'(REPEAT_RATE);
  localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(SEL_MAX);
  localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(SEL_INIT);

  logic             up_db, dn_db;
  logic             up_prev, dn_prev;
  step_state_t      state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             dir_up, dir_nxt;
  logic             step_up, step_dn;
  logic             held;
  logic [SEL_W-1:0] sel_inc, sel_dec;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_UP), .BTN_DB(up_db)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_DN), .BTN_DB(dn_db)
  );

  // FSM state, repeat timer, held direction and edge-detect history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      timer   <= '0;
      dir_up  <= 1'b0;
      up_prev <= 1'b0;
      dn_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      dir_up  <= dir_nxt;
      up_prev <= up_db;
      dn_prev <= dn_db;
    end
  end

  // Step decisions: first step on a rising debounced edge, then delay/repeat while held.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dir_nxt   = dir_up;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    held      = dir_up ? up_db : dn_db;
    if (up_db && dn_db) begin
      state_nxt = BOTH;
    end else begin
      case (state)
        IDLE: begin
          if (up_db && !up_prev) begin
            step_up   = 1'b1;
            dir_nxt   = 1'b1;
            state_nxt = DELAY;
            timer_nxt = DELAY_LD;
          end else if (dn_db && !dn_prev) begin
            step_dn   = 1'b1;
            dir_nxt   = 1'b0;
            state_nxt = DELAY;
            timer_nxt = DELAY_LD;
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state_nxt = IDLE;
          end else if (timer <= TMR_W'(1)) begin
            // Timer was loaded in the step cycle, so expiring at 1 spaces steps exactly.
            step_up   = dir_up;
            step_dn   = !dir_up;
            state_nxt = REPEAT;
            timer_nxt = RATE_LD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        BOTH: begin
          if (!up_db && !dn_db) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next SEL values for each direction at the bounds.
  always_comb begin
`ifdef SEL_WRAP_EN
    sel_inc  = (SEL >= SEL_TOP) ? '0 : SEL + 1'b1;
    sel_dec  = (SEL == '0) ? SEL_TOP : SEL - 1'b1;
    AT_LIMIT = 1'b0;
`else
    sel_inc  = (SEL < SEL_TOP) ? SEL + 1'b1 : SEL;
    sel_dec  = (SEL != '0) ? SEL - 1'b1 : SEL;
    AT_LIMIT = (SEL == '0) || (SEL == SEL_TOP);
`endif
  end

  // Register the strobes together with the SEL update they announce.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEL      <= SEL_RST;
      UP_PULSE <= 1'b0;
      DN_PULSE <= 1'b0;
    end else begin
      UP_PULSE <= step_up;
      DN_PULSE <= step_dn;
      if (step_up)      SEL <= sel_inc;
      else if (step_dn) SEL <= sel_dec;
    end
  end

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Directed bench for btn_sel_ctrl with short timing (DEB=4, DELAY=16, RATE=8).
// Inputs change on the falling edge; a monitor samples 2 ns after each rising edge.
module tb_btn_sel_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       BTN_UP;
  logic       BTN_DN;
  logic [4:0] SEL;
  logic       UP_PULSE;
  logic       DN_PULSE;
  logic       AT_LIMIT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int up_times[$];
  int dn_times[$];
  bit both_seen = 0;

  btn_sel_ctrl #(
    .SEL_W(5), .SEL_MAX(31), .SEL_INIT(0),
    .DEB_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
    .SEL(SEL), .UP_PULSE(UP_PULSE), .DN_PULSE(DN_PULSE), .AT_LIMIT(AT_LIMIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #2;
    if (UP_PULSE) begin up_cnt++; up_times.push_back(cyc); end
    if (DN_PULSE) begin dn_cnt++; dn_times.push_back(cyc); end
    if (UP_PULSE && DN_PULSE) both_seen = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Press one button for hold cycles, then release and let the FSM settle.
  task automatic press(input bit up, input int hold);
    if (up) BTN_UP = 1'b1; else BTN_DN = 1'b1;
    wait_cyc(hold);
    BTN_UP = 1'b0;
    BTN_DN = 1'b0;
    wait_cyc(12);
  endtask

  initial begin
    int c0, base, p, bu, bd;
    int offs[4] = '{16, 24, 32, 40};
    BTN_UP = 1'b0;
    BTN_DN = 1'b0;
    RST_N  = 1'b0;
    wait_cyc(3);

    // 1: reset state, then a clean press; pulse 6 cycles after the first sampling edge
    check("rst_sel", int'(SEL), 0);
    check("rst_up", int'(UP_PULSE), 0);
    check("rst_dn", int'(DN_PULSE), 0);
    check("rst_lim", int'(AT_LIMIT), 1);
    RST_N = 1'b1;
    wait_cyc(2);
    base = up_times.size();
    c0 = cyc;
    BTN_UP = 1'b1;
    wait_cyc(10);
    check("t1_count", up_times.size() - base, 1);
    if (up_times.size() > base) check("t1_latency", up_times[base] - (c0 + 1), 6);
    check("t1_sel", int'(SEL), 1);
    check("t1_lim", int'(AT_LIMIT), 0);
    BTN_UP = 1'b0;
    wait_cyc(12);

    // 2: bounce every 2 cycles produces nothing; stable level produces one step
    bu = up_cnt;
    for (int i = 0; i < 10; i++) begin
      BTN_UP = (i % 2 == 0);
      wait_cyc(2);
    end
    wait_cyc(4);
    check("t2_bounce", up_cnt - bu, 0);
    press(1'b1, 10);
    check("t2_count", up_cnt - bu, 1);
    check("t2_sel", int'(SEL), 2);

    // 3: hold -> steps at 0,16,24,32,40 then release before the 48 step
    base = up_times.size();
    BTN_UP = 1'b1;
    for (int i = 0; i < 20 && up_times.size() == base; i++) @(negedge CLK);
    check("t3_first_seen", int'(up_times.size() > base), 1);
    p = (up_times.size() > base) ? up_times[base] : cyc;
    wait_cyc(40);
    BTN_UP = 1'b0;
    wait_cyc(30);
    check("t3_count", up_times.size() - base, 5);
    for (int k = 0; k < 4; k++)
      if (up_times.size() > base + k + 1) check("t3_offset", up_times[base + k + 1] - p, offs[k]);
    check("t3_sel", int'(SEL), 7);

    // 5: simultaneous rise is ignored; after releasing both, DN works again
    bu = up_cnt;
    bd = dn_cnt;
    BTN_UP = 1'b1;
    BTN_DN = 1'b1;
    wait_cyc(40);
    check("t5_both_up", up_cnt - bu, 0);
    check("t5_both_dn", dn_cnt - bd, 0);
    check("t5_both_sel", int'(SEL), 7);
    BTN_UP = 1'b0;
    BTN_DN = 1'b0;
    wait_cyc(12);
    press(1'b0, 10);
    check("t5_dn_count", dn_cnt - bd, 1);
    check("t5_dn_sel", int'(SEL), 6);
    press(1'b0, 10);
    check("t5_dn2_sel", int'(SEL), 5);

    // 6: reset while in REPEAT at SEL=7; held button steps again after re-debounce
    base = up_times.size();
    BTN_UP = 1'b1;
    for (int i = 0; i < 40 && up_times.size() < base + 2; i++) @(negedge CLK);
    check("t6_pre_sel", int'(SEL), 7);
    wait_cyc(2);
    RST_N = 1'b0;
    #1;
    check("t6_rst_sel", int'(SEL), 0);
    check("t6_rst_up", int'(UP_PULSE), 0);
    check("t6_rst_dn", int'(DN_PULSE), 0);
    wait_cyc(2);
    base = up_times.size();
    c0 = cyc;
    RST_N = 1'b1;
    wait_cyc(10);
    check("t6_count", up_times.size() - base, 1);
    if (up_times.size() > base) check("t6_latency", up_times[base] - (c0 + 1), 6);
    check("t6_sel", int'(SEL), 1);
    BTN_UP = 1'b0;
    wait_cyc(12);

    // 4: bound behaviour
    press(1'b0, 10);
    check("t4_dn_to0", int'(SEL), 0);
    bd = dn_cnt;
    press(1'b0, 10);
    check("t4_dn_pulse", dn_cnt - bd, 1);
`ifdef SEL_WRAP_EN
    check("t4_dn_wrap", int'(SEL), 31);
    check("t4_dn_lim", int'(AT_LIMIT), 0);
    bu = up_cnt;
    press(1'b1, 10);
    check("t4_up_pulse", up_cnt - bu, 1);
    check("t4_up_wrap", int'(SEL), 0);
    check("t4_up_lim", int'(AT_LIMIT), 0);
`else
    check("t4_dn_sat", int'(SEL), 0);
    check("t4_dn_lim", int'(AT_LIMIT), 1);
    BTN_UP = 1'b1;
    for (int i = 0; i < 400 && SEL != 5'd31; i++) @(negedge CLK);
    check("t4_reach_top", int'(SEL), 31);
    bu = up_cnt;
    wait_cyc(12);
    check("t4_up_pulse", int'(up_cnt > bu), 1);
    check("t4_up_sat", int'(SEL), 31);
    check("t4_up_lim", int'(AT_LIMIT), 1);
    BTN_UP = 1'b0;
    wait_cyc(12);
`endif

    check("never_both_pulses", int'(both_seen), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
